// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-port data RAM.
// Port 0 (CPU) reads and writes; port 1 (display fetch) only reads. Either
// port can lock the RAM for a burst of up to MAX_BURST consecutive grants.
// Build option DMEM_ARB_RR_EN: when defined, simultaneous requests in IDLE
// alternate between the ports. When undefined, port 0 wins every tie.
module dmem_arbiter #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic              lock0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_wEn,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dataIn,
  input  logic [DATA_W-1:0] ram_dataOut
);

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  // Set for one cycle after a burst hits MAX_BURST; rel_port_q names the port
  // that must yield a tie in that cycle.
  logic              rel_q, rel_d;
  logic              rel_port_q, rel_port_d;
  logic              rv0_q, rv1_q;
  logic [DATA_W-1:0] hold0_q, hold1_q;
  logic              g0, g1;
  logic              own_hold;
  logic              tie1;

`ifdef DMEM_ARB_RR_EN
  logic last_q;

  // Round-robin pointer: remembers the port served most recently.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (g0) begin
      last_q <= 1'b0;
    end else if (g1) begin
      last_q <= 1'b1;
    end
  end
`endif

  // FSM state register with burst counter and release flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rel_q      <= 1'b0;
      rel_port_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rel_q      <= rel_d;
      rel_port_q <= rel_port_d;
    end
  end

  // Output decode: pick the winner from state and the current requests.
  always_comb begin
    own_hold = 1'b0;
    g0       = 1'b0;
    g1       = 1'b0;
    tie1     = 1'b0;
`ifdef DMEM_ARB_RR_EN
    tie1     = ~last_q;
`endif
    if (state_q == OWN0 && req0 && lock0) begin
      own_hold = 1'b1;
      g0       = 1'b1;
    end else if (state_q == OWN1 && req1 && lock1) begin
      own_hold = 1'b1;
      g1       = 1'b1;
    end else if (req0 && req1) begin
      // An owner whose lock lapsed competes exactly as it would from IDLE.
      if (rel_q) begin
        g0 = rel_port_q;
        g1 = ~rel_port_q;
      end else begin
        g0 = ~tie1;
        g1 = tie1;
      end
    end else begin
      g0 = req0;
      g1 = req1;
    end
    if (reset) begin
      own_hold = 1'b0;
      g0       = 1'b0;
      g1       = 1'b0;
    end
  end

  // Next-state: enter OWNn on a locked grant, leave on lock loss or full burst.
  always_comb begin
    state_d    = IDLE;
    cnt_d      = '0;
    rel_d      = 1'b0;
    rel_port_d = rel_port_q;
    if (own_hold) begin
      if (cnt_q + 4'd1 >= MAX_B) begin
        rel_d      = 1'b1;
        rel_port_d = g1;
      end else begin
        state_d = state_q;
        cnt_d   = cnt_q + 4'd1;
      end
    end else if ((g0 && lock0) || (g1 && lock1)) begin
      if (MAX_B <= 4'd1) begin
        rel_d      = 1'b1;
        rel_port_d = g1;
      end else begin
        state_d = g1 ? OWN1 : OWN0;
        cnt_d   = 4'd1;
      end
    end
  end

  // Read-return tracking: one-cycle rvalid after a read grant, data held after.
  always_ff @(posedge clock) begin
    if (reset) begin
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      hold0_q <= '0;
      hold1_q <= '0;
    end else begin
      rv0_q <= g0 & ~we0;
      rv1_q <= g1;
      if (rv0_q) begin
        hold0_q <= ram_dataOut;
      end
      if (rv1_q) begin
        hold1_q <= ram_dataOut;
      end
    end
  end

  assign gnt0       = g0;
  assign gnt1       = g1;
  assign ram_wEn    = g0 & we0;
  assign ram_addr   = g0 ? addr0 : (g1 ? addr1 : '0);
  assign ram_dataIn = (g0 | g1) ? wdata0 : '0;
  // Gating by reset suppresses a read return that was in flight when reset rose.
  assign rvalid0    = rv0_q & ~reset;
  assign rvalid1    = rv1_q & ~reset;
  assign rdata0     = reset ? '0 : (rv0_q ? ram_dataOut : hold0_q);
  assign rdata1     = reset ? '0 : (rv1_q ? ram_dataOut : hold1_q);

endmodule
